// File: rtl/sub8_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub8_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF = 8;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(W_DEF);

endpackage

// File: rtl/sub8_serial_full_sub1.sv
// 1-bit full-subtractor cell: d = x - y - bin, bout set when the column borrows.
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial W-bit subtractor (a - b, LSB first) with start/done handshake.
// Optional compare flags (eq, lt_u, lt_s) are built when SUB8_SERIAL_CMP_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one difference bit per clock, W clocks
// DONE  | result valid, done pulses; start here chains the next operation
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         out_b,
  output logic         out_flower
`ifdef SUB8_SERIAL_CMP_EN
  ,
  output logic         eq,
  output logic         lt_u,
  output logic         lt_s
`endif
);

  localparam int CW = cnt_w(W);

  state_t         r_state;
  state_t         w_state_next;
  logic           w_accept;
  logic           w_last;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_a_msb;
  logic           r_b_msb;
  logic           r_bor;
  logic [CW-1:0]  r_cnt;
  logic [W-2:0]   r_acc;
  logic [W-1:0]   w_cat;
  logic           w_d;
  logic           w_bout;
  logic           w_ovf;
  logic [W-1:0]   r_out;
  logic           r_out_b;
  logic           r_ovf;

  full_sub1 u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  // Newest bit enters at the MSB; after W bits the concatenation is the full result.
  assign w_cat  = {w_d, r_acc};
  assign w_last = (r_state == RUN) && (r_cnt == CW'(W - 1));
  assign w_ovf  = (r_a_msb != r_b_msb) && (w_d != r_a_msb);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_bor   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_out_b <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_a_msb <= a[W-1];
      r_b_msb <= b[W-1];
      r_bor   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_a   <= {1'b0, r_a[W-1:1]};
      r_b   <= {1'b0, r_b[W-1:1]};
      r_acc <= w_cat[W-1:1];
      r_bor <= w_bout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_out   <= w_cat;
        r_out_b <= w_bout;
        r_ovf   <= w_ovf;
      end
    end
  end

`ifdef SUB8_SERIAL_CMP_EN
  logic r_eq;
  logic r_lt_u;
  logic r_lt_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eq   <= 1'b0;
      r_lt_u <= 1'b0;
      r_lt_s <= 1'b0;
    end else if (!w_accept && w_last) begin
      r_eq   <= (w_cat == '0);
      r_lt_u <= w_bout;
      r_lt_s <= w_d ^ w_ovf;
    end
  end

  assign eq   = r_eq;
  assign lt_u = r_lt_u;
  assign lt_s = r_lt_s;
`endif

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign out        = r_out;
  assign out_b      = r_out_b;
  assign out_flower = r_ovf;

endmodule

// File: tb/tb_sub8_serial.sv
// Directed bench for sub8_serial (W=8): latency, flags, ignored start, mid-run reset, back-to-back.
module tb_sub8_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       out_b;
  logic       out_flower;
`ifdef SUB8_SERIAL_CMP_EN
  logic       eq;
  logic       lt_u;
  logic       lt_s;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sub8_serial #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .out_b      (out_b),
    .out_flower (out_flower)
`ifdef SUB8_SERIAL_CMP_EN
    ,
    .eq         (eq),
    .lt_u       (lt_u),
    .lt_s       (lt_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [7:0] eo, input logic eb, input logic ef);
    chk({tag, "_out"}, {24'd0, out}, {24'd0, eo});
    chk({tag, "_borrow"}, {31'd0, out_b}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, out_flower}, {31'd0, ef});
`ifdef SUB8_SERIAL_CMP_EN
    chk({tag, "_eq"}, {31'd0, eq}, {31'd0, (eo == 8'h00)});
    chk({tag, "_lt_u"}, {31'd0, lt_u}, {31'd0, eb});
    chk({tag, "_lt_s"}, {31'd0, lt_s}, {31'd0, eo[7] ^ ef});
`endif
  endtask

  // Raise start with the operands, then count edges until done (bounded).
  // ign_at > 0 pulses start with other operands during that RUN cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int ign_at,
                        output int n_edges, output int n_busy, output int n_overlap);
    n_edges   = 0;
    n_busy    = 0;
    n_overlap = 0;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      n_edges = n;
      if (n == 1) start = 1'b0;
      if (ign_at > 0 && n == ign_at) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end
      if (ign_at > 0 && n == ign_at + 1) start = 1'b0;
      if (busy) n_busy++;
      if (busy && done) n_overlap++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  logic [7:0] vec_a  [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hFF};
  logic [7:0] vec_b  [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF};
  logic [7:0] vec_o  [5] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00};
  logic       vec_bo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       vec_f  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int         idx    [5] = '{0, 1, 2, 4, 3};

  initial begin
    int ne, nb, nov, seen;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_result("rst", 8'h00, 1'b0, 1'b0);

    // last vector (0x7F - 0xFF) leaves nonzero flags for the reset check below
    for (int k = 0; k < 5; k++) begin
      int i;
      i = idx[k];
      run_op(vec_a[i], vec_b[i], 0, ne, nb, nov);
      chk($sformatf("v%0d_latency", i), ne, 9);
      chk($sformatf("v%0d_busy_cycles", i), nb, 8);
      chk($sformatf("v%0d_overlap", i), nov, 0);
      chk_result($sformatf("v%0d", i), vec_o[i], vec_bo[i], vec_f[i]);
    end

    // result must hold while idle
    repeat (3) @(posedge clk);
    #1;
    chk_result("hold", 8'h80, 1'b1, 1'b1);

    // reset during RUN cycle 4
    a     = 8'h55;
    b     = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk_result("midrst", 8'h00, 1'b0, 1'b0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midrst_quiet", seen, 0);

    run_op(8'h00, 8'h01, 0, ne, nb, nov);
    chk("after_rst_latency", ne, 9);
    chk_result("after_rst", 8'hFF, 1'b1, 1'b0);

    // start during RUN cycle 3 must be ignored
    run_op(8'h40, 8'h10, 3, ne, nb, nov);
    chk("ign_latency", ne, 9);
    chk_result("ign", 8'h30, 1'b0, 1'b0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("ign_no_second_done", seen, 0);

    // back-to-back: start held through DONE
    a     = 8'h05;
    b     = 8'h03;
    start = 1'b1;
    ne    = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      ne = n;
      if (done) break;
    end
    chk("b2b_first_latency", ne, 9);
    chk_result("b2b_first", 8'h02, 1'b0, 1'b0);
    a = 8'h80;
    b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
    chk("b2b_restart_done", {31'd0, done}, 32'd0);
    chk_result("b2b_hold", 8'h02, 1'b0, 1'b0);
    ne = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      ne = n;
      if (done) break;
    end
    chk("b2b_gap", ne + 1, 9);
    chk_result("b2b_second", 8'h7F, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
